// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write path: size codes,
// FSM states and the timeout counter width.
package store_rmw_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10
  } state_e;

  localparam int TIMEOUT_DEF = 16;
  localparam int TO_W        = $clog2(TIMEOUT_DEF + 1);

  function automatic int to_width(input int t);
    return $clog2(t + 1);
  endfunction

  // Illegal size, or a half/word that does not sit on its natural boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      SZ_WORD: return |lane;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the truncated store data into its
// little-endian lane of an existing word, keeping the other lanes.
module store_lane_merge
  import store_rmw_unit_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_merged
);

  logic [4:0] w_bsh;
  logic [4:0] w_hsh;

  assign w_bsh = {i_lane, 3'b000};
  assign w_hsh = {i_lane[1], 4'b0000};

  always_comb begin
    o_merged = i_old_word;
    case (i_size)
      SZ_BYTE: o_merged[w_bsh +: 8]  = i_data[7:0];
      SZ_HALF: o_merged[w_hsh +: 16] = i_data[15:0];
      SZ_WORD: o_merged              = i_data;
      default: o_merged              = i_old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a data memory without byte enables: SB/SH go through a
// read-modify-write, SW writes directly; one request in flight at a time.
module store_rmw_unit
  import store_rmw_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int CNT_W = to_width(TIMEOUT);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-3:0] r_addr;
  logic [1:0]        r_size;
  logic [1:0]        r_lane;
  logic [31:0]       r_data;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_mis;
  logic              r_berr;

  logic              w_accept;
  logic              w_bad;
  logic              w_last;
  logic [31:0]       w_merged;

  assign w_accept = req_valid && (r_state == IDLE);
  assign w_bad    = misaligned(req_size, req_addr[1:0]);
  // Last allowed wait cycle; a response in this same cycle still wins.
  assign w_last   = (r_cnt == CNT_W'(TIMEOUT - 1));

  store_lane_merge u_merge (
    .i_old_word (mem_rdata),
    .i_data     (r_data),
    .i_size     (r_size),
    .i_lane     (r_lane),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
      r_data  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_addr <= req_addr[ADDR_W-1:2];
            r_size <= req_size;
            r_lane <= req_addr[1:0];
            r_data <= req_data;
            if (w_bad) begin
              r_mis <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              r_wdata <= req_data;
              r_state <= WR;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: begin
          if (mem_rvalid) begin
            r_wdata <= w_merged;
            r_cnt   <= '0;
            r_state <= WR;
          end else if (w_last) begin
            r_berr  <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WR: begin
          if (mem_ack) begin
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (w_last) begin
            r_berr  <= 1'b1;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register so an async reset
  // drops them at once.
  assign req_ready    = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign mem_rd       = (r_state == RD);
  assign mem_wr       = (r_state == WR);
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign done         = r_done;
  assign misalign_err = r_mis;
  assign bus_err      = r_berr;

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart of the load path's sign/zero extension: narrows a 32-bit register value to byte, halfword or word and merges it into a 32-bit-wide data memory that has no byte enables.
- Performs read-modify-write for SB/SH and a direct write for SW.
- Sits between the MEM stage and data memory.
- Holds one request at a time and stalls the pipeline through `req_ready`/`busy`.

Parameters:
- ADDR_W, 32, byte-address width of `req_addr`; `mem_addr` is ADDR_W-2 bits (word address).
- TIMEOUT, 16, max cycles to wait for `mem_rvalid`/`mem_ack` before abort; must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_size  input  2  00=byte, 01=half, 10=word, 11=illegal.
- req_addr  input  ADDR_W  byte address.
- req_data  input  32  register value; low bits used for byte/half.
- mem_addr  output  ADDR_W-2  word address, registered.
- mem_rd  output  1  read strobe, held until `mem_rvalid`.
- mem_rdata  input  32  read word.
- mem_rvalid  input  1  `mem_rdata` valid this cycle.
- mem_wr  output  1  write strobe, held until `mem_ack`.
- mem_wdata  output  32  merged write word, registered.
- mem_ack  input  1  write accepted.
- busy  output  1  request in flight (state ≠ IDLE).
- done  output  1  one-cycle pulse: store completed.
- misalign_err  output  1  one-cycle pulse: request rejected.
- bus_err  output  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0 except `req_ready`=1.
  - `mem_addr`/`mem_wdata`=0.
  - Timeout counter=0.
- Accept:
  - Handshake occurs when `req_valid` && `req_ready`.
  - `req_ready`=1 only in IDLE.
  - Address, size, data and lane are latched on accept.
- Misalignment:
  - Half with addr[0]=1, word with addr[1:0]≠0, or size=11 is rejected.
  - `misalign_err` pulses the cycle after accept.
  - No memory access; state stays IDLE.
- Lane order is little-endian:
  - byte lane = addr[1:0] → bits [8k+7:8k].
  - half lane = addr[1] → bits [16h+15:16h].
- States:
  - IDLE → RD (byte/half) or WR (word) on a legal accept.
  - RD:
    - `mem_rd`=1.
    - On `mem_rvalid`: merge lanes into `mem_wdata`, then → WR.
    - Unselected lanes come from `mem_rdata`; selected lanes come from the truncated `req_data`.
  - WR:
    - `mem_wr`=1.
    - On `mem_ack`: `done` pulses next cycle, → IDLE.
  - Word store: `mem_wdata`=`req_data` unchanged.
- Latency with zero-wait memory (`mem_rvalid`/`mem_ack` the same cycle the strobe is high):
  - SW: accept at T, `mem_wr` T+1, `done` T+2.
  - SB/SH: accept at T, `mem_rd` T+1, `mem_wr` T+2, `done` T+3.
- Timeout:
  - Counter clears on each state entry and increments each cycle in RD/WR without a response.
  - Reaching TIMEOUT drops the strobe, pulses `bus_err`, returns to IDLE.
  - Memory is not written on a RD timeout.
- Response ordering:
  - `mem_rvalid` in WR and `mem_ack` in RD are ignored.
  - A response arriving in the same cycle the counter hits TIMEOUT wins: no abort.
- Back-to-back:
  - A new request can be accepted in the cycle `done`, `misalign_err` or `bus_err` is asserted, since state is IDLE.
  - No combinational path exists from `req_valid` to `mem_*`.
- Reset mid-operation: strobes drop immediately (async), no `done`; a partial RMW leaves memory unchanged.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state enum IDLE/RD/WR.
  - timeout width localparam $clog2(TIMEOUT+1).
- One combinational sub-module `store_lane_merge` takes (old_word, data, size, addr[1:0]) and returns merged_word. It is reusable by a future store buffer.

Test Plan:
- Reset with rst_n=0 mid-RD → `mem_rd`=0 immediately, `req_ready`=1 after release, no `done`.
- SB addr=0x0000_0103, data=0xAABB_CC5A, memory word 0x1122_3344, zero-wait → `mem_rd` addr 0x40, `mem_wdata`=0x5A22_3344, `done` at T+3.
- SH addr=0x0000_0012, data=0x0000_BEEF, memory word 0xDEAD_0000 → `mem_wdata`=0xBEEF_0000; SW addr=0x20, data=0xCAFE_F00D → no `mem_rd`, `mem_wdata`=0xCAFE_F00D, `done` at T+2.
- SH addr=0x0000_0001 and SW addr=0x0000_0006 → `misalign_err` pulse each, `mem_rd`=`mem_wr`=0 throughout.
- SB with `mem_rvalid` never asserted, TIMEOUT=16 → `mem_rd` high 16 cycles, then `bus_err` pulse, no `mem_wr`; `mem_rvalid` on exactly the 16th cycle → proceeds to WR.
- Three SB requests with `req_valid` held continuously, memory 2-cycle wait states → each accepted in its completion cycle, merged words correct, `done` count=3.
